// File: rtl/dpmem_pkg.sv
// dpmem_pkg: shared definitions for the dual-port memory arbiter.
//   NREQ           - number of requesters
//   port_sel_e     - which memory port (if any) a requester was granted
//   dpmem_conflict - same-address pair with at least one write
//   dpmem_onehot   - requester index to one-hot mask
package dpmem_pkg;

    localparam int NREQ       = 4;
    localparam int MAX_ADDR_W = 64;

    typedef enum logic [1:0] {
        PORT_NONE = 2'd0,
        PORT_A    = 2'd1,
        PORT_B    = 2'd2
    } port_sel_e;

    // Addresses are zero-extended to MAX_ADDR_W by the caller.
    function automatic logic dpmem_conflict(
        input logic [MAX_ADDR_W-1:0] addr_x,
        input logic                  we_x,
        input logic [MAX_ADDR_W-1:0] addr_y,
        input logic                  we_y
    );
        return (addr_x == addr_y) && (we_x || we_y);
    endfunction

    function automatic logic [NREQ-1:0] dpmem_onehot(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/dpmem_rr_pick.sv
// dpmem_rr_pick: combinational round-robin picker.
// Scans eligible requesters starting at the pointer. The first hit is the
// port A grant; the next hit that does not conflict with it is the port B grant.
//   i_elig  - in-range eligible mask
//   i_ptr   - round-robin start index
//   i_conf  - conflict matrix, bit {x,y} set when requesters x and y conflict
//   o_a_*   - first grant (valid flag + index)
//   o_b_*   - second grant (valid flag + index)
module dpmem_rr_pick
    import dpmem_pkg::*;
(
    input  logic [NREQ-1:0]      i_elig,
    input  logic [1:0]           i_ptr,
    input  logic [NREQ*NREQ-1:0] i_conf,
    output logic                 o_a_vld,
    output logic [1:0]           o_a_idx,
    output logic                 o_b_vld,
    output logic [1:0]           o_b_idx
);

    logic [1:0] w_idx;

    // Rotating scan; conflicting candidates are skipped and stay pending.
    always_comb begin
        o_a_vld = 1'b0;
        o_a_idx = 2'd0;
        o_b_vld = 1'b0;
        o_b_idx = 2'd0;
        w_idx   = 2'd0;
        for (int k = 0; k < NREQ; k++) begin
            w_idx = i_ptr + k[1:0];
            if (i_elig[w_idx]) begin
                if (!o_a_vld) begin
                    o_a_vld = 1'b1;
                    o_a_idx = w_idx;
                end else if (!o_b_vld && !i_conf[{o_a_idx, w_idx}]) begin
                    o_b_vld = 1'b1;
                    o_b_idx = w_idx;
                end else begin
                    o_b_vld = o_b_vld;
                end
            end else begin
                w_idx = w_idx;
            end
        end
    end

endmodule

// File: rtl/dpmem_arb.sv
// dpmem_arb: four-requester round-robin arbiter/sequencer in front of a
// dual-port memory. Maps up to two requests per cycle onto ports A and B,
// never pairs a same-address access where either side writes, flags
// out-of-range addresses, and steers read data back to its owner.
//   clk, reset_b          - clock, async active-low reset
//   req/req_we/req_addr/req_wdata - per-requester request slices
//   ack/err/rvalid/rdata  - per-requester responses (registered pulses)
//   addra/wea/oea/da, qa  - memory port A
//   addrb/web/oeb/db, qb  - memory port B
module dpmem_arb
    import dpmem_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int MEM_SIZE   = 1024
) (
    input  logic                       clk,
    input  logic                       reset_b,
    input  logic [NREQ-1:0]            req,
    input  logic [NREQ-1:0]            req_we,
    input  logic [NREQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NREQ*32-1:0]         req_wdata,
    output logic [NREQ-1:0]            ack,
    output logic [NREQ-1:0]            err,
    output logic [NREQ-1:0]            rvalid,
    output logic [NREQ*32-1:0]         rdata,
    output logic [ADDR_WIDTH-1:0]      addra,
    output logic [ADDR_WIDTH-1:0]      addrb,
    output logic                       wea,
    output logic                       web,
    output logic                       oea,
    output logic                       oeb,
    output logic [31:0]                da,
    output logic [31:0]                db,
    input  logic [31:0]                qa,
    input  logic [31:0]                qb
);

    localparam logic [ADDR_WIDTH:0] MEM_LIM = (ADDR_WIDTH + 1)'(MEM_SIZE);

    logic [ADDR_WIDTH-1:0] w_addr  [NREQ];
    logic [31:0]           w_wdata [NREQ];
    port_sel_e             w_sel   [NREQ];
    logic [NREQ-1:0]       w_elig, w_inr, w_elig_ok, w_err_nx, w_ack_nx;
    logic [NREQ*NREQ-1:0]  w_conf;
    logic                  w_a_vld, w_b_vld;
    logic [1:0]            w_a_idx, w_b_idx, w_ptr_nx;
    logic [NREQ*32-1:0]    w_rdata;

    logic [NREQ-1:0]       r_ack, r_err, r_rvalid;
    logic [1:0]            r_ptr;
    logic [ADDR_WIDTH-1:0] r_addra, r_addrb;
    logic                  r_wea, r_web, r_oea, r_oeb;
    logic [31:0]           r_da, r_db;
    logic                  r_rd_pend_a, r_rd_pend_b;
    logic [1:0]            r_own_a, r_own_b, r_rsel_a, r_rsel_b;

    // Unpack request slices, classify eligibility and build the conflict matrix.
    always_comb begin
        w_conf = '0;
        w_inr  = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_addr[i]  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            w_wdata[i] = req_wdata[i*32 +: 32];
            w_inr[i]   = ({1'b0, w_addr[i]} < MEM_LIM);
        end
        for (int i = 0; i < NREQ; i++) begin
            for (int j = 0; j < NREQ; j++) begin
                if (i != j) begin
                    w_conf[i*NREQ + j] = dpmem_conflict(MAX_ADDR_W'(w_addr[i]), req_we[i],
                                                        MAX_ADDR_W'(w_addr[j]), req_we[j]);
                end else begin
                    w_conf[i*NREQ + j] = 1'b0;
                end
            end
        end
        // A requester is masked during its own ack cycle.
        w_elig    = req & ~r_ack;
        w_elig_ok = w_elig & w_inr;
        w_err_nx  = w_elig & ~w_inr;
    end

    dpmem_rr_pick u_pick (
        .i_elig  (w_elig_ok),
        .i_ptr   (r_ptr),
        .i_conf  (w_conf),
        .o_a_vld (w_a_vld),
        .o_a_idx (w_a_idx),
        .o_b_vld (w_b_vld),
        .o_b_idx (w_b_idx)
    );

    // Per-requester port assignment, next ack mask and next pointer.
    always_comb begin
        w_ack_nx = w_err_nx;
        for (int i = 0; i < NREQ; i++) begin
            if (w_a_vld && (w_a_idx == i[1:0])) begin
                w_sel[i] = PORT_A;
            end else if (w_b_vld && (w_b_idx == i[1:0])) begin
                w_sel[i] = PORT_B;
            end else begin
                w_sel[i] = PORT_NONE;
            end
            if (w_sel[i] != PORT_NONE) begin
                w_ack_nx[i] = 1'b1;
            end else begin
                w_ack_nx[i] = w_err_nx[i];
            end
        end
        // Pointer moves past the last port-granted requester; errors never move it.
        if (w_b_vld) begin
            w_ptr_nx = w_b_idx + 2'd1;
        end else if (w_a_vld) begin
            w_ptr_nx = w_a_idx + 2'd1;
        end else begin
            w_ptr_nx = r_ptr;
        end
    end

    // Arbiter state, memory port registers and two-stage read return pipeline.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            r_ack       <= 4'b0000;
            r_err       <= 4'b0000;
            r_rvalid    <= 4'b0000;
            r_ptr       <= 2'd0;
            r_addra     <= '0;
            r_addrb     <= '0;
            r_wea       <= 1'b0;
            r_web       <= 1'b0;
            r_oea       <= 1'b0;
            r_oeb       <= 1'b0;
            r_da        <= 32'd0;
            r_db        <= 32'd0;
            r_rd_pend_a <= 1'b0;
            r_rd_pend_b <= 1'b0;
            r_own_a     <= 2'd0;
            r_own_b     <= 2'd0;
            r_rsel_a    <= 2'd0;
            r_rsel_b    <= 2'd0;
        end else begin
            r_ack <= w_ack_nx;
            r_err <= w_err_nx;
            r_ptr <= w_ptr_nx;
            // Idle port keeps address/data, only write enable drops.
            if (w_a_vld) begin
                r_addra <= w_addr[w_a_idx];
                r_wea   <= req_we[w_a_idx];
                r_da    <= w_wdata[w_a_idx];
            end else begin
                r_wea   <= 1'b0;
            end
            if (w_b_vld) begin
                r_addrb <= w_addr[w_b_idx];
                r_web   <= req_we[w_b_idx];
                r_db    <= w_wdata[w_b_idx];
            end else begin
                r_web   <= 1'b0;
            end
            // Stage 1: remember granted reads; stage 2: oe + rvalid.
            r_rd_pend_a <= w_a_vld && !req_we[w_a_idx];
            r_rd_pend_b <= w_b_vld && !req_we[w_b_idx];
            r_own_a     <= w_a_idx;
            r_own_b     <= w_b_idx;
            r_oea       <= r_rd_pend_a;
            r_oeb       <= r_rd_pend_b;
            r_rsel_a    <= r_own_a;
            r_rsel_b    <= r_own_b;
            r_rvalid    <= (r_rd_pend_a ? dpmem_onehot(r_own_a) : 4'b0000)
                         | (r_rd_pend_b ? dpmem_onehot(r_own_b) : 4'b0000);
        end
    end

    // Steer port read data to the owning requester slice; others read 0.
    always_comb begin
        w_rdata = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (r_oea && (r_rsel_a == i[1:0])) begin
                w_rdata[i*32 +: 32] = qa;
            end else if (r_oeb && (r_rsel_b == i[1:0])) begin
                w_rdata[i*32 +: 32] = qb;
            end else begin
                w_rdata[i*32 +: 32] = 32'd0;
            end
        end
    end

    assign ack    = r_ack;
    assign err    = r_err;
    assign rvalid = r_rvalid;
    assign rdata  = w_rdata;
    assign addra  = r_addra;
    assign addrb  = r_addrb;
    assign wea    = r_wea;
    assign web    = r_web;
    assign oea    = r_oea;
    assign oeb    = r_oeb;
    assign da     = r_da;
    assign db     = r_db;

endmodule

// File: tb/tb_dpmem_arb.sv
// Directed bench for dpmem_arb with a simple registered-read memory model.
module tb_dpmem_arb;

    logic         clk = 1'b0;
    logic         reset_b;
    logic [3:0]   req, req_we;
    logic [127:0] req_addr, req_wdata;
    logic [3:0]   ack, err, rvalid;
    logic [127:0] rdata;
    logic [31:0]  addra, addrb, da, db, qa, qb;
    logic         wea, web, oea, oeb;

    logic [31:0]  mem [0:1023];
    int           errors = 0;
    int           checks = 0;

    dpmem_arb #(.ADDR_WIDTH(32), .MEM_SIZE(1024)) dut (
        .clk(clk), .reset_b(reset_b), .req(req), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .ack(ack), .err(err),
        .rvalid(rvalid), .rdata(rdata), .addra(addra), .addrb(addrb),
        .wea(wea), .web(web), .oea(oea), .oeb(oeb), .da(da), .db(db),
        .qa(qa), .qb(qb)
    );

    always #5 clk = ~clk;

    // Memory model: writes and read sampling on the rising edge.
    always @(posedge clk) begin
        if (wea) mem[addra[9:0]] <= da;
        if (web) mem[addrb[9:0]] <= db;
        qa <= mem[addra[9:0]];
        qb <= mem[addrb[9:0]];
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int i, input logic we_v, input logic [31:0] a, input logic [31:0] d);
        req[i]               = 1'b1;
        req_we[i]            = we_v;
        req_addr[i*32 +: 32]  = a;
        req_wdata[i*32 +: 32] = d;
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = {16'hC0DE, 16'(i)};
        qa = 32'd0; qb = 32'd0;
        reset_b = 1'b0;
        req = 4'b0; req_we = 4'b0; req_addr = '0; req_wdata = '0;
        #12;
        chk("rst_ack", {ack, err, rvalid}, 12'h000);
        chk("rst_port", {wea, web, oea, oeb}, 4'b0000);
        chk("rst_addr", {addra, addrb, da, db}, 128'd0);
        reset_b = 1'b1;

        // Single read: preload mem[5] via requester 0, read it back via requester 1.
        drive(0, 1'b1, 32'd5, 32'hA5A5_0005);
        step; // E1
        chk("wr5_ack", ack, 4'b0001);
        chk("wr5_port", {wea, addra, da}, {1'b1, 32'd5, 32'hA5A5_0005});
        req = 4'b0000;
        drive(1, 1'b0, 32'd5, 32'd0);
        step; // E2
        chk("rd5_ack", ack, 4'b0010);
        chk("rd5_port", {wea, oea, addra}, {1'b0, 1'b0, 32'd5});
        req = 4'b0000;
        drive(3, 1'b1, 32'd7, 32'h7777_0007);
        step; // E3
        chk("rd5_ret", {oea, rvalid}, {1'b1, 4'b0010});
        chk("rd5_data", rdata, {32'd0, 32'd0, 32'hA5A5_0005, 32'd0});
        chk("wr7_ack", {ack, wea, addra}, {4'b1000, 1'b1, 32'd7});

        // Four reads with pointer at 0.
        req = 4'b0000;
        drive(0, 1'b0, 32'd1, 32'd0);
        drive(1, 1'b0, 32'd2, 32'd0);
        drive(2, 1'b0, 32'd3, 32'd0);
        drive(3, 1'b0, 32'd4, 32'd0);
        step; // E4
        chk("four_ack1", ack, 4'b0011);
        chk("four_port1", {addra, addrb, wea, web}, {32'd1, 32'd2, 2'b00});
        req = 4'b1100;
        step; // E5
        chk("four_ack2", ack, 4'b1100);
        chk("four_port2", {addra, addrb}, {32'd3, 32'd4});
        chk("four_rv1", {oea, oeb, rvalid}, {2'b11, 4'b0011});
        chk("four_data1", rdata, {64'd0, 32'hC0DE_0002, 32'hC0DE_0001});

        // Write/read conflict on addr 9 at pointer 0.
        req = 4'b0000;
        drive(0, 1'b1, 32'd9, 32'h9999_0009);
        drive(1, 1'b0, 32'd9, 32'd0);
        step; // E6
        chk("four_rv2", rvalid, 4'b1100);
        chk("four_data2", rdata, {32'hC0DE_0004, 32'hC0DE_0003, 64'd0});
        chk("conf_ack1", {ack, wea, web, addra}, {4'b0001, 2'b10, 32'd9});
        req[0] = 1'b0;
        step; // E7
        chk("conf_ack2", {ack, wea, addra}, {4'b0010, 1'b0, 32'd9});

        // Same-address reads by requesters 2 and 3.
        req = 4'b0000;
        drive(2, 1'b0, 32'd7, 32'd0);
        drive(3, 1'b0, 32'd7, 32'd0);
        step; // E8
        chk("conf_rd", {oea, rvalid}, {1'b1, 4'b0010});
        chk("conf_data", rdata, {64'd0, 32'h9999_0009, 32'd0});
        chk("same_ack", {ack, addra, addrb}, {4'b1100, 32'd7, 32'd7});
        req = 4'b0000;
        drive(0, 1'b0, 32'd1, 32'd0);
        step; // E9: pointer becomes 1
        chk("same_rv", {oea, oeb, rvalid}, {2'b11, 4'b1100});
        chk("same_data", rdata, {32'h7777_0007, 32'h7777_0007, 64'd0});
        chk("p1_ack", {ack, addra}, {4'b0001, 32'd1});
        req = 4'b0000;
        step; // E10
        chk("p1_rv", {oea, rvalid, rdata}, {1'b1, 4'b0001, 96'd0, 32'hC0DE_0001});

        // Out-of-range: no ports, no rvalid, pointer stays at 1.
        drive(3, 1'b0, 32'd1024, 32'd0);
        step; // E11
        chk("oor_ack", {ack, err}, {4'b1000, 4'b1000});
        chk("oor_port", {wea, web, oea, oeb, addra, addrb}, {4'b0000, 32'd1, 32'd7});
        req = 4'b0000;
        step; // E12
        chk("oor_quiet", {ack, err, rvalid, oea, oeb}, 14'd0);
        drive(0, 1'b0, 32'd2, 32'd0);
        drive(1, 1'b0, 32'd3, 32'd0);
        step; // E13: requester 1 first (p=1)
        chk("oor_ptr", {ack, addra, addrb}, {4'b0011, 32'd3, 32'd2});
        req = 4'b0000;
        step; // E14
        chk("oor_ptr_data", {rvalid, rdata}, {4'b0011, 64'd0, 32'hC0DE_0003, 32'hC0DE_0002});

        // Reset in cycle 1 of a read.
        drive(2, 1'b0, 32'd4, 32'd0);
        step; // E15
        chk("mid_ack", {ack, addra}, {4'b0100, 32'd4});
        req = 4'b0000;
        #2 reset_b = 1'b0;
        #1;
        chk("mid_rst", {ack, err, rvalid, wea, web, oea, oeb}, 16'd0);
        chk("mid_rst_addr", {addra, addrb, da, db}, 128'd0);
        #2 reset_b = 1'b1;
        step; // E16
        chk("mid_norv1", {rvalid, oea, oeb}, 6'd0);
        step; // E17
        chk("mid_norv2", {rvalid, oea, oeb}, 6'd0);
        drive(1, 1'b0, 32'd5, 32'd0);
        drive(3, 1'b0, 32'd6, 32'd0);
        step; // E18: p=0 so requester 1 takes port A
        chk("mid_ptr", {ack, addra, addrb}, {4'b1010, 32'd5, 32'd6});
        req = 4'b0000;
        step; // E19
        chk("mid_data", {rvalid, rdata}, {4'b1010, 32'hC0DE_0006, 32'd0, 32'hA5A5_0005, 32'd0});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
